// File: rtl/mem_port_arbiter_if.sv
// Bundles the port-controller and buffer-memory signals of the packet-buffer arbiter.
// Latency: none. This file only declares wires.
// Backpressure: per-port requests are held until granted; the read side applies no backpressure to memory.
interface mem_port_arbiter_if #(
    parameter int N          = 4,
    parameter int ADDR_W     = 12,
    parameter int BLOCK_BITS = 512
);
    logic [N-1:0]                 wr_req;
    logic [N-1:0][ADDR_W-1:0]     wr_addr;
    logic [N-1:0][BLOCK_BITS-1:0] wr_data;
    logic [N-1:0]                 wr_lock;
    logic [N-1:0]                 wr_gnt;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_waddr;
    logic [BLOCK_BITS-1:0]        mem_wdata;
    logic [N-1:0]                 rd_req;
    logic [N-1:0][ADDR_W-1:0]     rd_addr;
    logic [N-1:0]                 rd_gnt;
    logic                         mem_re;
    logic [ADDR_W-1:0]            mem_raddr;
    logic                         mem_rvalid;
    logic [BLOCK_BITS-1:0]        mem_rdata;
    logic [N-1:0]                 rd_valid;
    logic [BLOCK_BITS-1:0]        rd_data;
    logic                         rd_err;

    // Port controllers and the memory wrapper drive requests and read data.
    modport master (
        output wr_req, wr_addr, wr_data, wr_lock, rd_req, rd_addr, mem_rvalid, mem_rdata,
        input  wr_gnt, mem_we, mem_waddr, mem_wdata, rd_gnt, mem_re, mem_raddr,
               rd_valid, rd_data, rd_err
    );

    // The arbiter returns grants, memory commands and routed read responses.
    modport slave (
        input  wr_req, wr_addr, wr_data, wr_lock, rd_req, rd_addr, mem_rvalid, mem_rdata,
        output wr_gnt, mem_we, mem_waddr, mem_wdata, rd_gnt, mem_re, mem_raddr,
               rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin write/read arbiter from N ports to the buffer SRAM, with a read tag FIFO routing responses back.
// Latency: grant is combinational; memory command is 1 cycle after transfer; response is 1 cycle after mem_rvalid.
// Backpressure: held requests; reads stall at MAX_OUTST in flight. Optional write lock via MEM_ARB_LOCK_EN.
module mem_port_arbiter #(
    parameter int N          = 4,
    parameter int ADDR_W     = 12,
    parameter int BLOCK_BITS = 512,
    parameter int MAX_OUTST  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int IW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    // First requester at or after ptr, searched modulo N (works for any N).
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
        logic [N-1:0] gnt;
        logic         found;
        int           idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[PW'(idx)]) begin
                gnt[PW'(idx)] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [PW-1:0] oh2idx(input logic [N-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++)
            if (oh[i]) idx = idx | PW'(i);
        return idx;
    endfunction

    // Explicit wrap so a non-power-of-two N never visits an unused port id.
    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IW-1:0] next_slot(input logic [IW-1:0] s);
        return (s == IW'(MAX_OUTST - 1)) ? '0 : s + 1'b1;
    endfunction

    logic [PW-1:0] wr_ptr;
    logic [N-1:0]  wr_gnt;
    logic          wr_xfer;
    logic [PW-1:0] wr_sel;

    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] tag_wp;
    logic [IW-1:0] tag_rp;
    logic [PW-1:0] tags [MAX_OUTST];
    logic [N-1:0]  rd_gnt;
    logic          push;
    logic          pop;
    logic          err;
    logic [PW-1:0] rd_sel;
    logic [N-1:0]  rv_next;

`ifdef MEM_ARB_LOCK_EN
    logic          lock_vld;
    logic [PW-1:0] lock_own;

    // While a lock is held only its owner is eligible, regardless of the pointer.
    always_comb begin
        wr_gnt = rr_pick(bus.wr_req, wr_ptr);
        if (lock_vld) begin
            wr_gnt           = '0;
            wr_gnt[lock_own] = bus.wr_req[lock_own];
        end
    end

    // Lock owner tracking: a locked beat claims or keeps ownership, an unlocked beat releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld <= 1'b0;
            lock_own <= '0;
        end else if (wr_xfer) begin
            lock_vld <= bus.wr_lock[wr_sel];
            lock_own <= wr_sel;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.wr_lock;

    // Every write beat is arbitrated independently.
    always_comb begin
        wr_gnt = rr_pick(bus.wr_req, wr_ptr);
    end
`endif

    assign bus.wr_gnt = wr_gnt;
    assign wr_xfer    = |wr_gnt;
    assign wr_sel     = oh2idx(wr_gnt);

    // Write pointer advance and registered memory write command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= wr_xfer;
            if (wr_xfer) begin
                bus.mem_waddr <= bus.wr_addr[wr_sel];
                bus.mem_wdata <= bus.wr_data[wr_sel];
`ifdef MEM_ARB_LOCK_EN
                if (!bus.wr_lock[wr_sel]) wr_ptr <= next_port(wr_sel);
`else
                wr_ptr <= next_port(wr_sel);
`endif
            end
        end
    end

    // Read grant gated on the occupancy before this cycle's pop, then tag FIFO head decode.
    always_comb begin
        rd_gnt  = (cnt < CW'(MAX_OUTST)) ? rr_pick(bus.rd_req, rd_ptr) : '0;
        push    = |rd_gnt;
        rd_sel  = oh2idx(rd_gnt);
        pop     = bus.mem_rvalid && (cnt != '0);
        err     = bus.mem_rvalid && (cnt == '0);
        rv_next = '0;
        if (pop) rv_next[tags[tag_rp]] = 1'b1;
    end

    assign bus.rd_gnt = rd_gnt;

    // Tag storage needs no reset: entries are only read when cnt says they are valid.
    always_ff @(posedge clk) begin
        if (push) tags[tag_wp] <= rd_sel;
    end

    // Read pointer, FIFO bookkeeping, memory read command and routed response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            cnt           <= '0;
            tag_wp        <= '0;
            tag_rp        <= '0;
            bus.mem_re    <= 1'b0;
            bus.mem_raddr <= '0;
            bus.rd_valid  <= '0;
            bus.rd_data   <= '0;
            bus.rd_err    <= 1'b0;
        end else begin
            bus.mem_re   <= push;
            bus.rd_valid <= rv_next;
            bus.rd_err   <= err;
            if (push) begin
                bus.mem_raddr <= bus.rd_addr[rd_sel];
                rd_ptr        <= next_port(rd_sel);
                tag_wp        <= next_slot(tag_wp);
            end
            if (pop) begin
                bus.rd_data <= bus.mem_rdata;
                tag_rp      <= next_slot(tag_rp);
            end
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: outputs are sampled 1 time unit after the rising edge; grants are sampled mid-cycle.
// Backpressure: the bench drives requests freely; memory returns are random or scripted.
module tb_mem_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int BB = 512;
    localparam int MO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.N(N), .ADDR_W(AW), .BLOCK_BITS(BB)) bus ();
    mem_port_arbiter_if #(.N(3), .ADDR_W(AW), .BLOCK_BITS(BB)) bus3 ();

    mem_port_arbiter #(.N(N), .ADDR_W(AW), .BLOCK_BITS(BB), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    mem_port_arbiter #(.N(3), .ADDR_W(AW), .BLOCK_BITS(BB), .MAX_OUTST(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    int vectors = 0;
    int errors  = 0;

    // Reference model: pointers as integers, outstanding reads as a queue of port ids.
    int              m_wr_ptr, m_rd_ptr, m_lock_own;
    bit              m_lock_vld;
    int              q[$];
    logic            exp_we, exp_re, exp_err;
    logic [AW-1:0]   exp_waddr, exp_raddr;
    logic [BB-1:0]   exp_wdata, exp_rdata;
    logic [N-1:0]    exp_rvalid;

    function automatic logic [BB-1:0] rand_blk();
        logic [BB-1:0] b;
        for (int i = 0; i < BB / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Winner is the requester at the smallest forward distance from the pointer.
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int p = 0; p < N; p++) begin
            if (req[p]) begin
                d = (p - ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = p;
                end
            end
        end
        return best;
    endfunction

    function automatic int model_wr();
`ifdef MEM_ARB_LOCK_EN
        if (m_lock_vld) return bus.wr_req[m_lock_own] ? m_lock_own : -1;
`endif
        return pick(bus.wr_req, m_wr_ptr);
    endfunction

    function automatic int model_rd();
        return (q.size() < MO) ? pick(bus.rd_req, m_rd_ptr) : -1;
    endfunction

    function automatic logic [N-1:0] oh(input int p);
        logic [N-1:0] v;
        v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.wr_req  = '0; bus.wr_lock = '0; bus.rd_req = '0; bus.mem_rvalid = 1'b0;
        bus3.wr_req = '0; bus3.wr_lock = '0; bus3.rd_req = '0; bus3.mem_rvalid = 1'b0;
        for (int p = 0; p < N; p++) begin
            bus.wr_addr[p] = '0; bus.rd_addr[p] = '0; bus.wr_data[p] = '0;
        end
        for (int p = 0; p < 3; p++) begin
            bus3.wr_addr[p] = '0; bus3.rd_addr[p] = '0; bus3.wr_data[p] = '0;
        end
        bus.mem_rdata = '0; bus3.mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_wr_ptr = 0; m_rd_ptr = 0; m_lock_vld = 0; m_lock_own = 0;
        q.delete();
        exp_we = 0; exp_re = 0; exp_err = 0; exp_rvalid = '0;
        exp_waddr = '0; exp_raddr = '0; exp_wdata = '0; exp_rdata = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied, then step the DUT.
    task automatic tick();
        int w, r, t;
        w = model_wr();
        r = model_rd();
        exp_we = (w >= 0);
        if (w >= 0) begin
            exp_waddr = bus.wr_addr[w];
            exp_wdata = bus.wr_data[w];
`ifdef MEM_ARB_LOCK_EN
            if (bus.wr_lock[w]) begin
                m_lock_vld = 1; m_lock_own = w;
            end else begin
                m_lock_vld = 0; m_wr_ptr = (w + 1) % N;
            end
`else
            m_wr_ptr = (w + 1) % N;
`endif
        end
        exp_rvalid = '0;
        exp_err    = 1'b0;
        if (bus.mem_rvalid) begin
            if (q.size() == 0) exp_err = 1'b1;
            else begin
                t = q.pop_front();
                exp_rvalid[t] = 1'b1;
                exp_rdata     = bus.mem_rdata;
            end
        end
        exp_re = (r >= 0);
        if (r >= 0) begin
            exp_raddr = bus.rd_addr[r];
            m_rd_ptr  = (r + 1) % N;
            q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({bus.mem_we, bus.mem_re, bus.rd_err} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b want 000", {bus.mem_we, bus.mem_re, bus.rd_err});
        end
        vectors++;
        if ({bus.rd_valid, bus.wr_gnt, bus.rd_gnt} !== '0) begin
            errors++; $display("FAIL reset_vectors: got %b want 0", {bus.rd_valid, bus.wr_gnt, bus.rd_gnt});
        end
        vectors++;
        if ({bus.mem_waddr, bus.mem_raddr} !== '0 || bus.rd_data !== '0 || bus.mem_wdata !== '0) begin
            errors++; $display("FAIL reset_data: waddr %h raddr %h want 0", bus.mem_waddr, bus.mem_raddr);
        end
        do_reset();
    endtask

    task automatic test_write_rr();
        int ord[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int p = 0; p < N; p++) bus.wr_addr[p] = AW'(16 * p + 1);
        bus.wr_req = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (bus.wr_gnt !== oh(ord[k])) begin
                errors++; $display("FAIL wr_rr_gnt beat %0d: got %b want %b", k, bus.wr_gnt, oh(ord[k]));
            end
            if (k > 0) begin
                vectors++;
                if (bus.mem_we !== 1'b1 || bus.mem_waddr !== AW'(16 * ord[k-1] + 1)) begin
                    errors++; $display("FAIL wr_rr_addr beat %0d: got we=%b addr %h want we=1 addr %h",
                                       k, bus.mem_we, bus.mem_waddr, AW'(16 * ord[k-1] + 1));
                end
            end
            @(posedge clk);
            #1;
        end
        bus.wr_req = '0;
    endtask

    task automatic test_n3();
        int ord[5] = '{1, 2, 1, 2, 1};
        do_reset();
        for (int p = 0; p < 3; p++) bus3.wr_addr[p] = AW'(32 + p);
        bus3.wr_req = 3'b110;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (bus3.wr_gnt !== 3'(1 << ord[k])) begin
                errors++; $display("FAIL n3_gnt beat %0d: got %b want %b", k, bus3.wr_gnt, 3'(1 << ord[k]));
            end
            @(posedge clk);
            #1;
            vectors++;
            if (bus3.mem_waddr !== AW'(32 + ord[k])) begin
                errors++; $display("FAIL n3_addr beat %0d: got %h want %h", k, bus3.mem_waddr, AW'(32 + ord[k]));
            end
        end
        bus3.wr_req = '0;
    endtask

    task automatic test_read_order();
        int seq[3] = '{3, 0, 2};
        int gap[3] = '{1, 3, 0};
        logic [BB-1:0] d;
        do_reset();
        for (int p = 0; p < N; p++) bus.rd_addr[p] = AW'(100 + p);
        for (int k = 0; k < 3; k++) begin
            bus.rd_req = oh(seq[k]);
            #1;
            vectors++;
            if (bus.rd_gnt !== oh(seq[k])) begin
                errors++; $display("FAIL rd_issue_gnt %0d: got %b want %b", k, bus.rd_gnt, oh(seq[k]));
            end
            @(posedge clk);
            #1;
            vectors++;
            if (bus.mem_re !== 1'b1 || bus.mem_raddr !== AW'(100 + seq[k])) begin
                errors++; $display("FAIL rd_issue_addr %0d: got re=%b %h want re=1 %h",
                                   k, bus.mem_re, bus.mem_raddr, AW'(100 + seq[k]));
            end
        end
        bus.rd_req = '0;
        for (int k = 0; k < 3; k++) begin
            repeat (gap[k]) begin
                @(posedge clk);
                #1;
            end
            d = rand_blk();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = d;
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            vectors++;
            if (bus.rd_valid !== oh(seq[k]) || bus.rd_err !== 1'b0) begin
                errors++; $display("FAIL rd_return_port %0d: got %b err=%b want %b err=0",
                                   k, bus.rd_valid, bus.rd_err, oh(seq[k]));
            end
            vectors++;
            if (bus.rd_data !== d) begin
                errors++; $display("FAIL rd_return_data %0d: got %h want %h", k, bus.rd_data, d);
            end
        end
    endtask

    task automatic test_full();
        int grants = 0;
        do_reset();
        bus.rd_req = '1;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (|bus.rd_gnt) grants++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (grants !== MO) begin
            errors++; $display("FAIL full_grant_count: got %0d want %0d", grants, MO);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rand_blk();
        #1;
        vectors++;
        if (bus.rd_gnt !== '0) begin
            errors++; $display("FAIL full_pop_same_cycle: got %b want 0000", bus.rd_gnt);
        end
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        vectors++;
        if (bus.rd_valid !== 4'b0001) begin
            errors++; $display("FAIL full_first_return: got %b want 0001", bus.rd_valid);
        end
        vectors++;
        if (bus.rd_gnt !== 4'b0001) begin
            errors++; $display("FAIL full_regrant: got %b want 0001", bus.rd_gnt);
        end
        bus.rd_req = '0;
    endtask

    task automatic test_reset_outstanding();
        do_reset();
        bus.rd_req = 4'b0011;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.rd_req = '0;
        rst_n = 1'b0;
        #2;
        vectors++;
        if (bus.mem_re !== 1'b0 || bus.mem_raddr !== '0) begin
            errors++; $display("FAIL rst_async_clear: got re=%b addr %h want 0", bus.mem_re, bus.mem_raddr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rand_blk();
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        vectors++;
        if (bus.rd_err !== 1'b1 || bus.rd_valid !== '0) begin
            errors++; $display("FAIL rst_orphan_err: got err=%b valid=%b want err=1 valid=0000", bus.rd_err, bus.rd_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.rd_err !== 1'b0) begin
            errors++; $display("FAIL rst_err_pulse: got %b want 0", bus.rd_err);
        end
    endtask

    task automatic test_lock();
        logic [N-1:0] req[4]  = '{4'b0100, 4'b0101, 4'b0101, 4'b0001};
        logic [N-1:0] lck[4]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
`ifdef MEM_ARB_LOCK_EN
        int           want[4] = '{2, 2, 2, 0};
`else
        int           want[4] = '{2, 0, 2, 0};
`endif
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.wr_req  = req[k];
            bus.wr_lock = lck[k];
            #1;
            vectors++;
            if (bus.wr_gnt !== oh(want[k])) begin
                errors++; $display("FAIL lock_gnt beat %0d: got %b want %b", k, bus.wr_gnt, oh(want[k]));
            end
            @(posedge clk);
            #1;
        end
        bus.wr_req  = '0;
        bus.wr_lock = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.wr_req     = N'($urandom);
            bus.wr_lock    = N'($urandom) & N'($urandom);
            bus.rd_req     = N'($urandom) & N'($urandom);
            bus.mem_rvalid = ($urandom_range(0, 2) == 0);
            bus.mem_rdata  = rand_blk();
            for (int p = 0; p < N; p++) begin
                bus.wr_addr[p] = AW'($urandom);
                bus.rd_addr[p] = AW'($urandom);
                bus.wr_data[p] = rand_blk();
            end
            #1;
            vectors++;
            if (bus.wr_gnt !== oh(model_wr())) begin
                errors++; $display("FAIL rnd_wr_gnt cyc %0d: got %b want %b", c, bus.wr_gnt, oh(model_wr()));
            end
            vectors++;
            if (bus.rd_gnt !== oh(model_rd())) begin
                errors++; $display("FAIL rnd_rd_gnt cyc %0d: got %b want %b", c, bus.rd_gnt, oh(model_rd()));
            end
            tick();
            vectors++;
            if (bus.mem_we !== exp_we || bus.mem_waddr !== exp_waddr || bus.mem_wdata !== exp_wdata) begin
                errors++; $display("FAIL rnd_write cyc %0d: got we=%b addr %h want we=%b addr %h",
                                   c, bus.mem_we, bus.mem_waddr, exp_we, exp_waddr);
            end
            vectors++;
            if (bus.mem_re !== exp_re || bus.mem_raddr !== exp_raddr) begin
                errors++; $display("FAIL rnd_read_issue cyc %0d: got re=%b addr %h want re=%b addr %h",
                                   c, bus.mem_re, bus.mem_raddr, exp_re, exp_raddr);
            end
            vectors++;
            if (bus.rd_valid !== exp_rvalid || bus.rd_err !== exp_err || bus.rd_data !== exp_rdata) begin
                errors++; $display("FAIL rnd_response cyc %0d: got valid=%b err=%b want valid=%b err=%b",
                                   c, bus.rd_valid, bus.rd_err, exp_rvalid, exp_err);
            end
        end
        idle_inputs();
    endtask

    // Run all scenarios in order and report.
    initial begin
        test_reset();
        test_write_rr();
        test_n3();
        test_read_order();
        test_full();
        test_reset_outstanding();
        test_lock();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
